// File: rtl/sync_fifo_pkg.sv
// Shared constants and helpers for the single-clock FIFO.
package sync_fifo_pkg;

    localparam int DEF_DATA_W   = 8;
    localparam int DEF_DEPTH    = 16;
    localparam int DEF_AE_LEVEL = 2;
    localparam int DEF_FWFT     = 1;

    // Pointer width: one extra bit above the address so full and empty differ.
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // Legal configurations: DEPTH is a power of two >= 2 and the thresholds are ordered.
    function automatic bit params_ok(input int depth, input int ae_level, input int af_level);
        bit pow2;
        pow2 = (depth >= 2) && ((depth & (depth - 1)) == 0);
        return pow2 && (ae_level >= 0) && (ae_level < af_level) && (af_level <= depth);
    endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// FIFO storage: one registered write port, one combinational read port, no reset.
module sync_fifo_mem #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Store the incoming word; contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/sync_fifo.sv
// Parametrised single-clock FIFO with FWFT/standard read, occupancy, thresholds and sticky errors.
module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = DEF_AE_LEVEL,
    parameter int FWFT     = DEF_FWFT
) (
    input  logic                      clka,
    input  logic                      resetb_clka,
    input  logic [DATA_W-1:0]         din_clka,
    input  logic                      wr_en_clka,
    output logic                      full_clka,
    output logic                      almost_full_clka,
    input  logic                      rd_en_clka,
    output logic [DATA_W-1:0]         dout_clka,
    output logic                      empty_clka,
    output logic                      almost_empty_clka,
    output logic [ptr_w(DEPTH)-1:0]   count_clka,
    output logic                      overflow_clka,
    output logic                      underflow_clka,
    input  logic                      clr_err_clka
);

    localparam int PW = ptr_w(DEPTH);
    localparam int AW = PW - 1;

    if (!params_ok(DEPTH, AE_LEVEL, AF_LEVEL)) begin : g_param_check
        $error("sync_fifo: DEPTH must be a power of two >= 2 and 0 <= AE_LEVEL < AF_LEVEL <= DEPTH");
    end

    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]     count_q, count_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;
    logic              full_w, empty_w;
    logic              wr_accept, rd_accept;
    logic [DATA_W-1:0] mem_rd_data;

    // Flags come only from the registered count, so they never follow the request inputs.
    assign full_w            = (count_q == PW'(DEPTH));
    assign empty_w           = (count_q == '0);
    assign full_clka         = full_w;
    assign empty_clka        = empty_w;
    assign almost_full_clka  = (count_q >= PW'(AF_LEVEL));
    assign almost_empty_clka = (count_q <= PW'(AE_LEVEL));
    assign count_clka        = count_q;
    assign overflow_clka     = overflow_q;
    assign underflow_clka    = underflow_q;

    // A full FIFO refuses writes even when a read frees a slot in the same cycle, and vice versa.
    assign wr_accept = wr_en_clka & ~full_w;
    assign rd_accept = rd_en_clka & ~empty_w;

    sync_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_mem (
        .clk     (clka),
        .wr_en   (wr_accept),
        .wr_addr (wr_ptr_q[AW-1:0]),
        .wr_data (din_clka),
        .rd_addr (rd_ptr_q[AW-1:0]),
        .rd_data (mem_rd_data)
    );

    // Next pointers and occupancy; simultaneous accepted read and write leave count unchanged.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_accept) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (rd_accept) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({wr_accept, rd_accept})
            2'b10:   count_d = count_q + PW'(1);
            2'b01:   count_d = count_q - PW'(1);
            default: count_d = count_q;
        endcase
    end

    // Sticky error flags; a fresh error in the same cycle as a clear keeps the flag set.
    always_comb begin
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (clr_err_clka) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
        if (wr_en_clka && full_w) begin
            overflow_d = 1'b1;
        end
        if (rd_en_clka && empty_w) begin
            underflow_d = 1'b1;
        end
    end

    // Pointer, count and flag registers.
    always_ff @(posedge clka or negedge resetb_clka) begin
        if (!resetb_clka) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    if (FWFT != 0) begin : g_fwft
        // Head word shown directly; forced to zero while empty so reset reads back as zero.
        assign dout_clka = empty_w ? '0 : mem_rd_data;
    end else begin : g_std
        logic [DATA_W-1:0] dout_q, dout_d;

        // Load the head word only on an accepted read, otherwise hold.
        always_comb begin
            dout_d = dout_q;
            if (rd_accept) begin
                dout_d = mem_rd_data;
            end
        end

        // Registered read data.
        always_ff @(posedge clka or negedge resetb_clka) begin
            if (!resetb_clka) begin
                dout_q <= '0;
            end else begin
                dout_q <= dout_d;
            end
        end

        assign dout_clka = dout_q;
    end

endmodule
